// File: rtl/sdio_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : sdio_pixel_packer
//  Purpose  : Assembles 4-bit SDIO data nibbles into RGB565 pixel words and
//             issues sequential framebuffer write requests. Delimits frames
//             on sdio_cmd, tracks the write address, holds a single pending
//             write under backpressure and flags dropped words (sticky).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    H_RES      active pixels per line
//    V_RES      active lines per frame
//    ADDR_W     framebuffer address width, 2**ADDR_W >= H_RES*V_RES
//  Ports
//    sdio_clk   in   sole clock, rising edge
//    rst        in   asynchronous active-high reset
//    sdio_cmd   in   start-of-frame strobe (one cycle)
//    nib_valid  in   qualifies sdio_data
//    sdio_data  in   data nibble, MSB-first within a pixel
//    fb_ready   in   framebuffer accepts the pending write this cycle
//    pix_we     out  write request valid
//    pix_addr   out  write address
//    pix_data   out  RGB565 word
//    frame_done out  one-cycle pulse, last pixel of the frame accepted
//    overflow   out  sticky, a completed word was dropped
//    busy       out  receiving a frame or a write is pending
//    pix_rgb888 out  MSB-replicated 24-bit pixel
//                    (only when SDIO_PACKER_RGB888_EN is defined)
//  Configuration macro: SDIO_PACKER_RGB888_EN
// ============================================================================
module sdio_pixel_packer #(
    parameter int H_RES  = 800,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              sdio_clk,
    input  logic              rst,
    input  logic              sdio_cmd,
    input  logic              nib_valid,
    input  logic [3:0]        sdio_data,
    input  logic              fb_ready,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
`ifdef SDIO_PACKER_RGB888_EN
    ,
    output logic [23:0]       pix_rgb888
`endif
);

    // Index of the final word of a frame
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          nib_cnt_q;
    logic [ADDR_W-1:0]   word_cnt_q;
    // Only the three oldest nibbles need storing; the fourth is taken
    // straight from sdio_data when the word completes.
    logic [11:0]         shift_q;
    logic                pix_we_q;
    logic [ADDR_W-1:0]   pix_addr_q;
    logic [15:0]         pix_data_q;
    logic                last_q;       // pending write is the frame's final word
    logic                frame_done_q;
    logic                overflow_q;
`ifdef SDIO_PACKER_RGB888_EN
    logic [23:0]         rgb_q;
    logic [23:0]         rgb_d;
`endif

    logic [15:0]         word_d;
    logic                take_nib_d;
    logic                word_done_d;
    logic                accept_d;
    logic                pending_d;
    logic                is_last_d;

    always_comb begin
        word_d      = {shift_q, sdio_data};
        // Start strobe has priority over a coincident nibble
        take_nib_d  = (state_q == S_RECV) && nib_valid && !sdio_cmd;
        word_done_d = take_nib_d && (nib_cnt_q == 2'd3);
        accept_d    = pix_we_q && fb_ready;
        // A write that is not accepted this cycle blocks a new word
        pending_d   = pix_we_q && !fb_ready;
        is_last_d   = (word_cnt_q == c_LAST);
`ifdef SDIO_PACKER_RGB888_EN
        rgb_d = {word_d[15:11], word_d[15:13],
                 word_d[10:5],  word_d[10:9],
                 word_d[4:0],   word_d[4:2]};
`endif
    end

    always_ff @(posedge sdio_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nib_cnt_q    <= 2'd0;
            word_cnt_q   <= '0;
            shift_q      <= 12'd0;
            pix_we_q     <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= 16'd0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef SDIO_PACKER_RGB888_EN
            rgb_q        <= 24'd0;
`endif
        end else begin
            frame_done_q <= accept_d && last_q;

            // Accepted write retires unless overridden by a new word below
            if (accept_d) begin
                pix_we_q <= 1'b0;
            end

            if (sdio_cmd) begin
                // (Re)start: pending write, if any, is left untouched and
                // completes at its original address.
                state_q    <= S_RECV;
                nib_cnt_q  <= 2'd0;
                word_cnt_q <= '0;
                shift_q    <= 12'd0;
            end else if (take_nib_d) begin
                shift_q   <= word_d[11:0];
                nib_cnt_q <= nib_cnt_q + 2'd1;
                if (word_done_d) begin
                    if (pending_d) begin
                        overflow_q <= 1'b1;
                    end else begin
                        pix_we_q   <= 1'b1;
                        pix_data_q <= word_d;
                        pix_addr_q <= word_cnt_q;
                        last_q     <= is_last_d;
`ifdef SDIO_PACKER_RGB888_EN
                        rgb_q      <= rgb_d;
`endif
                    end
                    // Advance even on a drop so later pixels keep position
                    word_cnt_q <= word_cnt_q + ADDR_W'(1);
                    if (is_last_d) begin
                        state_q <= S_IDLE;
                    end
                end
            end
        end
    end

    assign pix_we     = pix_we_q;
    assign pix_addr   = pix_addr_q;
    assign pix_data   = pix_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == S_RECV) || pix_we_q;
`ifdef SDIO_PACKER_RGB888_EN
    assign pix_rgb888 = rgb_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdio_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdio_pixel_packer
//  Purpose  : Self-checking bench for sdio_pixel_packer (small 4x2 frame).
//             Directed steps followed by a randomized phase, all checked
//             against a queue-based transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdio_pixel_packer;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 3;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd = 1'b0;
    logic          nv  = 1'b0;
    logic [3:0]    d   = 4'd0;
    logic          rdy = 1'b0;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [15:0]   pix_data;
    logic          frame_done;
    logic          overflow;
    logic          busy;
`ifdef SDIO_PACKER_RGB888_EN
    logic [23:0]   pix_rgb888;
`endif

    sdio_pixel_packer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .sdio_clk   (clk),
        .rst        (rst),
        .sdio_cmd   (cmd),
        .nib_valid  (nv),
        .sdio_data  (d),
        .fb_ready   (rdy),
        .pix_we     (pix_we),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .overflow   (overflow),
        .busy       (busy)
`ifdef SDIO_PACKER_RGB888_EN
        ,
        .pix_rgb888 (pix_rgb888)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: frame progress as a nibble queue and a word index
    bit m_in_frame;
    int m_nibs[$];
    int m_widx;
    bit m_we;
    int m_addr;
    int m_data;
    bit m_last;
    bit m_done;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp888(input int p);
        int r, g, b;
        r = (p >> 11) & 31;
        g = (p >> 5) & 63;
        b = p & 31;
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    task automatic model_reset();
        m_in_frame = 0;
        m_nibs.delete();
        m_widx = 0;
        m_we   = 0;
        m_addr = 0;
        m_data = 0;
        m_last = 0;
        m_done = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input int n, input bit r);
        bit acc;
        int w;
        acc    = m_we && r;
        m_done = acc && m_last;
        if (acc) m_we = 0;
        if (c) begin
            m_in_frame = 1;
            m_nibs.delete();
            m_widx = 0;
        end else if (m_in_frame && v) begin
            m_nibs.push_back(n);
            if (m_nibs.size() == 4) begin
                w = (m_nibs[0] << 12) | (m_nibs[1] << 8) | (m_nibs[2] << 4) | m_nibs[3];
                m_nibs.delete();
                if (m_we) begin
                    m_ovf = 1;
                end else begin
                    m_we   = 1;
                    m_addr = m_widx;
                    m_data = w;
                    m_last = (m_widx == TOTAL - 1);
                end
                m_widx++;
                if (m_widx == TOTAL) m_in_frame = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("pix_we",     32'(pix_we),     32'(m_we));
        chk("pix_addr",   32'(pix_addr),   32'(m_addr));
        chk("pix_data",   32'(pix_data),   32'(m_data));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("busy",       32'(busy),       32'(m_in_frame || m_we));
`ifdef SDIO_PACKER_RGB888_EN
        chk("pix_rgb888", 32'(pix_rgb888), 32'(exp888(m_data)));
`endif
    endtask

    task automatic step(input bit c, input bit v, input logic [3:0] n, input bit r);
        @(negedge clk);
        cmd = c; nv = v; d = n; rdy = r;
        model_step(c, v, int'(n), r);
        @(posedge clk);
        #1;
        if (frame_done) done_seen++;
        check_all();
    endtask

    task automatic feed(input logic [3:0] n, input bit r);
        step(1'b0, 1'b1, n, r);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"},   32'(pix_we),     32'd0);
        chk({tag, "_addr"}, 32'(pix_addr),   32'd0);
        chk({tag, "_data"}, 32'(pix_data),   32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_ovf"},  32'(overflow),   32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'd0);
`ifdef SDIO_PACKER_RGB888_EN
        chk({tag, "_rgb"},  32'(pix_rgb888), 32'd0);
`endif
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // First pixel F,8,0,0 back-to-back
        step(1'b1, 1'b0, 4'h0, 1'b1);
        feed(4'hF, 1'b1);
        feed(4'h8, 1'b1);
        feed(4'h0, 1'b1);
        feed(4'h0, 1'b1);
        chk("t1_we",   32'(pix_we),   32'd1);
        chk("t1_data", 32'(pix_data), 32'hF800);
        chk("t1_addr", 32'(pix_addr), 32'd0);
`ifdef SDIO_PACKER_RGB888_EN
        chk("t1_rgb",  32'(pix_rgb888), 32'hFF0000);
`endif
        // Rest of the frame with fb_ready=1, then drain
        done_seen = 0;
        for (int i = 0; i < 4 * (TOTAL - 1); i++) feed(4'($urandom_range(0, 15)), 1'b1);
        chk("t2_last_addr", 32'(pix_addr), 32'(TOTAL - 1));
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        chk("t2_done_count", 32'(done_seen), 32'd1);
        chk("t2_idle", 32'(busy), 32'd0);
        // Frame over: nibbles without a start write nothing
        for (int i = 0; i < 8; i++) begin
            feed(4'($urandom_range(0, 15)), 1'b1);
            chk("t2_no_write", 32'(pix_we), 32'd0);
        end

        // Backpressure: two words complete while fb_ready=0
        step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) feed(4'(i + 1), 1'b0);
        chk("t3_hold_addr", 32'(pix_addr), 32'd0);
        chk("t3_hold_data", 32'(pix_data), 32'h1234);
        chk("t3_overflow",  32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) feed(4'(9 + i), 1'b1);
        chk("t3_next_addr", 32'(pix_addr), 32'd2);
        chk("t3_next_data", 32'(pix_data), 32'h9ABC);

        // Start with coincident nibble discards partial word
        step(1'b1, 1'b0, 4'h0, 1'b1);
        feed(4'h7, 1'b1);
        feed(4'h7, 1'b1);
        step(1'b1, 1'b1, 4'h7, 1'b1);
        feed(4'hA, 1'b1);
        feed(4'hB, 1'b1);
        feed(4'hC, 1'b1);
        feed(4'hD, 1'b1);
        chk("t4_data", 32'(pix_data), 32'hABCD);
        chk("t4_addr", 32'(pix_addr), 32'd0);

        // Pending write at addr 5 survives a restart
        step(1'b1, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 20; i++) feed(4'($urandom_range(0, 15)), 1'b1);
        feed(4'h5, 1'b1);
        feed(4'h5, 1'b0);
        feed(4'hA, 1'b0);
        feed(4'hA, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("t5_pend_addr", 32'(pix_addr), 32'd5);
        chk("t5_pend_data", 32'(pix_data), 32'h55AA);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        chk("t5_accepted", 32'(pix_we), 32'd0);
        for (int i = 0; i < 4; i++) feed(4'h3, 1'b1);
        chk("t5_new_addr", 32'(pix_addr), 32'd0);
        chk("t5_new_we",   32'(pix_we),   32'd1);

        // Asynchronous reset while pix_we=1
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            feed(4'($urandom_range(0, 15)), 1'b1);
            chk("t6_no_write", 32'(pix_we), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 8),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
